// File: rtl/trigger_sim_pkg.sv
// Shared constants and helpers for the crank-trigger wheel simulator.
package trigger_sim_pkg;

    localparam int DEF_TEETH_TOTAL   = 60;
    localparam int DEF_TEETH_MISSING = 2;
    localparam int DEF_PERIOD_W      = 24;
    localparam int DEF_HALF_PERIOD   = 2000;
    localparam int DEF_CAM_TEETH     = 3;
    localparam int MIN_HALF_PERIOD   = 2;

    // Two phase steps per tooth position: high half then low half.
    function automatic int phase_width(input int teeth_total);
        return $clog2(2 * teeth_total);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Half-tooth prescaler: one-cycle tick every active_period enabled clocks, restartable on period apply.
module tick_prescaler
    import trigger_sim_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] active_period,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;
    logic                at_end;

    // >= rather than == so a shrinking period can never strand the count above the terminal value.
    assign at_end = (count >= (active_period - PERIOD_W'(1)));
    assign tick   = enable && at_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/trigger_wheel_sim.sv
// N-minus-M crank trigger wheel generator with revolution sync, tooth index and runtime period reload.
// Optional cam-phase output is built when TRIGGER_SIM_CAM_EN is defined; otherwise cam_out is tied low.
module trigger_wheel_sim
    import trigger_sim_pkg::*;
#(
    parameter int TEETH_TOTAL         = DEF_TEETH_TOTAL,
    parameter int TEETH_MISSING       = DEF_TEETH_MISSING,
    parameter int PERIOD_W            = DEF_PERIOD_W,
    parameter int DEFAULT_HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int CAM_TEETH           = DEF_CAM_TEETH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [PERIOD_W-1:0]              half_period_in,
    input  logic                             half_period_load,
    output logic                             period_ack,
    output logic                             crank_out,
    output logic                             sync_out,
    output logic [$clog2(TEETH_TOTAL)-1:0]   tooth_index,
    output logic                             cam_out
);

    localparam int PHASE_W = phase_width(TEETH_TOTAL);
    localparam int IDX_W   = $clog2(TEETH_TOTAL);

    localparam logic [PHASE_W-1:0]  PHASE_LAST = PHASE_W'(2 * TEETH_TOTAL - 1);
    localparam logic [PHASE_W-1:0]  GAP_START  = PHASE_W'(2 * (TEETH_TOTAL - TEETH_MISSING));
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_HALF_PERIOD);
    localparam logic [PERIOD_W-1:0] DEF_P      = PERIOD_W'(DEFAULT_HALF_PERIOD);

    if (TEETH_TOTAL < 2 || TEETH_MISSING < 1 || TEETH_MISSING > TEETH_TOTAL - 1 ||
        DEFAULT_HALF_PERIOD < MIN_HALF_PERIOD || PERIOD_W < 2 ||
        $clog2(DEFAULT_HALF_PERIOD + 1) > PERIOD_W ||
        CAM_TEETH < 1 || CAM_TEETH > TEETH_TOTAL) begin : g_param_check
        $fatal(1, "trigger_wheel_sim: illegal parameter set");
    end

    logic [PHASE_W-1:0]  phase;
    logic [PERIOD_W-1:0] active_period;
    logic [PERIOD_W-1:0] pending_period;
    logic                pending_valid;
    logic                tick;
    logic                at_phase0;
    logic                apply;

    assign at_phase0 = (phase == '0);
    // Only swap periods at the revolution boundary, unless the wheel is frozen.
    assign apply     = pending_valid && ((tick && at_phase0) || !enable);

    tick_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .restart       (apply),
        .active_period (active_period),
        .tick          (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_period  <= DEF_P;
            pending_period <= DEF_P;
            pending_valid  <= 1'b0;
            period_ack     <= 1'b0;
        end else begin
            period_ack <= apply;
            if (apply) begin
                active_period <= pending_period;
            end
            // A load coinciding with apply stays pending; the older value is the one applied.
            if (half_period_load) begin
                pending_period <= (half_period_in < MIN_P) ? MIN_P : half_period_in;
                pending_valid  <= 1'b1;
            end else if (apply) begin
                pending_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase       <= '0;
            crank_out   <= 1'b0;
            sync_out    <= 1'b0;
            tooth_index <= '0;
        end else begin
            sync_out <= tick && at_phase0;
            if (tick) begin
                crank_out   <= (phase < GAP_START) ? ~phase[0] : 1'b0;
                tooth_index <= phase[PHASE_W-1:1];
                phase       <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
            end
        end
    end

`ifdef TRIGGER_SIM_CAM_EN
    logic rev_parity;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rev_parity <= 1'b0;
            cam_out    <= 1'b0;
        end else if (tick) begin
            if (phase == PHASE_LAST) begin
                rev_parity <= ~rev_parity;
            end
            // Widened compare so CAM_TEETH == TEETH_TOTAL does not truncate.
            cam_out <= rev_parity &&
                       ({1'b0, phase[PHASE_W-1:1]} < (IDX_W + 1)'(CAM_TEETH));
        end
    end
`else
    assign cam_out = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_wheel_sim.sv
// Directed self-checking bench for trigger_wheel_sim (60-2 wheel, half period 4 after reset).
// Cam checks follow TRIGGER_SIM_CAM_EN the same way the design does.
module tb_trigger_wheel_sim;

    localparam int T  = 60;
    localparam int M  = 2;
    localparam int PW = 24;
    localparam int DP = 4;
    localparam int CT = 3;

    logic                     clock;
    logic                     reset;
    logic                     enable;
    logic [PW-1:0]            half_period_in;
    logic                     half_period_load;
    logic                     period_ack;
    logic                     crank_out;
    logic                     sync_out;
    logic [$clog2(T)-1:0]     tooth_index;
    logic                     cam_out;

    int checks   = 0;
    int failures = 0;
    int cyc;

    // Waveform monitor state, sampled on the falling edge.
    int sync_count = 0, sync_cyc = 0, last_rev_len = 0;
    int rev_rises = 0, last_rev_rises = 0, low_run = 0, last_gap = 0;
    int ack_count = 0, last_ack_cyc = -1, rise_cyc = -1;
    int cam_rises = 0, cam_rise_cyc = -1, last_cam_len = 0;
    int sync_double = 0, ack_double = 0;
    logic prev_crank = 0, prev_sync = 0, prev_ack = 0, prev_cam = 0;

    trigger_wheel_sim #(
        .TEETH_TOTAL         (T),
        .TEETH_MISSING       (M),
        .PERIOD_W            (PW),
        .DEFAULT_HALF_PERIOD (DP),
        .CAM_TEETH           (CT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .half_period_in   (half_period_in),
        .half_period_load (half_period_load),
        .period_ack       (period_ack),
        .crank_out        (crank_out),
        .sync_out         (sync_out),
        .tooth_index      (tooth_index),
        .cam_out          (cam_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            sync_count = 0; sync_cyc = 0; last_rev_len = 0;
            rev_rises = 0; last_rev_rises = 0; low_run = 0; last_gap = 0;
            ack_count = 0; last_ack_cyc = -1; rise_cyc = -1;
            cam_rises = 0; cam_rise_cyc = -1; last_cam_len = 0;
            sync_double = 0; ack_double = 0;
            prev_crank = 0; prev_sync = 0; prev_ack = 0; prev_cam = 0;
        end else begin
            if (sync_out) begin
                last_rev_len   = cyc - sync_cyc;
                last_rev_rises = rev_rises;
                last_gap       = low_run;
                sync_cyc       = cyc;
                sync_count     = sync_count + 1;
                rev_rises      = 0;
                if (prev_sync) sync_double = sync_double + 1;
            end
            if (crank_out && !prev_crank) begin
                rev_rises = rev_rises + 1;
                rise_cyc  = cyc;
            end
            if (!crank_out) low_run = low_run + 1;
            else            low_run = 0;
            if (period_ack) begin
                ack_count    = ack_count + 1;
                last_ack_cyc = cyc;
                if (prev_ack) ack_double = ack_double + 1;
            end
            if (cam_out && !prev_cam) begin
                cam_rises    = cam_rises + 1;
                cam_rise_cyc = cyc;
            end
            if (!cam_out && prev_cam) last_cam_len = cyc - cam_rise_cyc;
            prev_crank = crank_out;
            prev_sync  = sync_out;
            prev_ack   = period_ack;
            prev_cam   = cam_out;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_sync(input string tag, input int budget);
        int start;
        int n;
        start = sync_count;
        n = 0;
        while (sync_count == start && n < budget) begin
            step();
            n++;
        end
        check({tag, "_sync_seen"}, int'(sync_count != start), 1);
    endtask

    task automatic wait_tooth(input string tag, input int idx, input logic level, input int budget);
        int n;
        n = 0;
        while (!(int'(tooth_index) == idx && crank_out == level) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reached"}, int'(int'(tooth_index) == idx && crank_out == level), 1);
    endtask

    task automatic load_period(input int value);
        half_period_in   = PW'(value);
        half_period_load = 1'b1;
        step();
        half_period_load = 1'b0;
    endtask

    initial begin
        int dev;
        int s_prev;
        reset            = 1'b1;
        enable           = 1'b1;
        half_period_in   = '0;
        half_period_load = 1'b0;
        repeat (3) step();

        check("rst_crank", int'(crank_out), 0);
        check("rst_sync",  int'(sync_out), 0);
        check("rst_ack",   int'(period_ack), 0);
        check("rst_idx",   int'(tooth_index), 0);
        check("rst_cam",   int'(cam_out), 0);
        reset = 1'b0;

        // Default period: first tooth, then two full revolutions.
        wait_sync("t1_first", 20);
        check("t1_first_sync_edge", sync_cyc, DP);
        check("t1_first_rise_edge", rise_cyc, DP);
        check("t1_tooth0_crank", int'(crank_out), 1);
        check("t1_tooth0_idx", int'(tooth_index), 0);
        check("t1_cam_rev0", int'(cam_out), 0);
        repeat (DP) step();
        check("t1_half1_crank", int'(crank_out), 0);
        check("t1_half1_idx", int'(tooth_index), 0);
        repeat (DP) step();
        check("t1_half2_crank", int'(crank_out), 1);
        check("t1_half2_idx", int'(tooth_index), 1);

        wait_sync("t1_rev1", 600);
        check("t1_rev1_len", last_rev_len, 480);
        check("t1_rev1_rises", last_rev_rises, 58);
        check("t1_rev1_gap", last_gap, 20);
`ifdef TRIGGER_SIM_CAM_EN
        check("t1_cam_rev1", int'(cam_out), 1);
`else
        check("t1_cam_rev1", int'(cam_out), 0);
`endif
        wait_sync("t1_rev2", 600);
        check("t1_rev2_len", last_rev_len, 480);
        check("t1_rev2_edge", sync_cyc, 964);
        check("t1_rev2_rises", last_rev_rises, 58);
        check("t1_cam_rev2", int'(cam_out), 0);
`ifdef TRIGGER_SIM_CAM_EN
        check("t1_cam_rises", cam_rises, 1);
        check("t1_cam_rise_edge", cam_rise_cyc, 484);
        check("t1_cam_len", last_cam_len, 6 * DP);
`else
        check("t1_cam_rises", cam_rises, 0);
`endif

        // Load 10 mid-revolution: takes effect only at the next revolution boundary.
        wait_tooth("t2_phase40", 20, 1'b1, 300);
        load_period(10);
        check("t2_no_early_ack", ack_count, 0);
        wait_sync("t2_boundary", 600);
        check("t2_old_rev_len", last_rev_len, 480);
        check("t2_ack_count", ack_count, 1);
        check("t2_ack_on_sync", last_ack_cyc, sync_cyc);
        wait_sync("t2_new_rev", 1500);
        check("t2_new_rev_len", last_rev_len, 1200);
        check("t2_new_rev_rises", last_rev_rises, 58);
        check("t2_new_rev_gap", last_gap, 50);

        // Load 0 clamps to the minimum half period of 2.
        load_period(0);
        wait_sync("t3_boundary", 1500);
        check("t3_old_rev_len", last_rev_len, 1200);
        check("t3_ack_count", ack_count, 2);
        check("t3_ack_on_sync", last_ack_cyc, sync_cyc);
        wait_sync("t3_new_rev", 400);
        check("t3_new_rev_len", last_rev_len, 240);
        check("t3_new_rev_rises", last_rev_rises, 58);
        check("t3_new_rev_gap", last_gap, 10);

        // Freeze mid-tooth for 50 clocks.
        repeat (7) step();
        check("t4_hold_crank", int'(crank_out), 0);
        check("t4_hold_idx", int'(tooth_index), 1);
        enable = 1'b0;
        dev = 0;
        repeat (50) begin
            step();
            if (crank_out !== 1'b0 || int'(tooth_index) != 1 || sync_out !== 1'b0 || period_ack !== 1'b0)
                dev++;
        end
        enable = 1'b1;
        check("t4_hold_deviations", dev, 0);
        wait_sync("t4_rev", 400);
        check("t4_rev_len", last_rev_len, 290);
        check("t4_rev_rises", last_rev_rises, 58);
        check("t4_no_ack", ack_count, 2);

        // Load while frozen: applies on the following cycle, prescaler restarts.
        s_prev = sync_cyc;
        enable = 1'b0;
        load_period(4);
        repeat (5) step();
        check("t4b_ack_count", ack_count, 3);
        check("t4b_ack_edge", last_ack_cyc, s_prev + 2);
        enable = 1'b1;
        wait_sync("t4b_rev", 600);
        check("t4b_rev_len", last_rev_len, 486);
        check("sync_single_cycle", sync_double, 0);
        check("ack_single_cycle", ack_double, 0);

        // Reset in the gap clears everything at once.
        wait_tooth("t5_gap", 58, 1'b0, 600);
        reset = 1'b1;
        #1;
        check("t5_rst_crank", int'(crank_out), 0);
        check("t5_rst_idx", int'(tooth_index), 0);
        check("t5_rst_sync", int'(sync_out), 0);
        check("t5_rst_ack", int'(period_ack), 0);
        check("t5_rst_cam", int'(cam_out), 0);
        repeat (2) step();
        reset = 1'b0;
        wait_sync("t5_first", 20);
        check("t5_first_sync_edge", sync_cyc, DP);
        check("t5_first_rise_edge", rise_cyc, DP);
        wait_sync("t5_rev", 600);
        check("t5_rev_len", last_rev_len, 480);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
